// File: rtl/seg7_pkg.sv
// Shared types for the multiplexed 7-segment scan controller.
package seg7_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      SHOW
   } scan_state_t;

   localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter: runs 0..SCAN_DIV-1 while scanning and flags the end of
// the guard interval and the end of the slot.
module seg7_slot_timer #(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic run_i,
   output logic guard_end_o,
   output logic slot_end_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign slot_end_o  = (cnt_q == SLOT_LAST);
   assign guard_end_o = (GUARD_CYCLES > 0) && (cnt_q == GUARD_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!(en_i && run_i)) begin
         cnt_d = '0;
      end else if (slot_end_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans packed BCD digits onto one shared decoder with guard gaps, leading-zero
// blanking and frame-synchronous value updates.
//   state | meaning
//   IDLE  | display dark, waiting for en
//   GUARD | start of a slot, all digits off (anti-ghosting)
//   SHOW  | digit idx enabled, its code on bcd_out
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    en_i,
   input  logic                    lz_en_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] digits_in_i,
   output logic                    load_ack_o,
   output logic [3:0]              bcd_out_o,
   output logic                    blank_out_o,
   output logic [NUM_DIGITS-1:0]   dig_sel_o,
   output logic                    frame_done_o,
   output logic                    bcd_err_o
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam int DW = 4 * NUM_DIGITS;

   if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("NUM_DIGITS must be at least 1");
   end
   if (GUARD_CYCLES < 0) begin : g_bad_guard
      $error("GUARD_CYCLES must be non-negative");
   end
   if (SCAN_DIV <= GUARD_CYCLES) begin : g_bad_div
      $error("SCAN_DIV must exceed GUARD_CYCLES");
   end

   scan_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    active_q, active_d;
   logic [DW-1:0]    shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             ack_q, ack_d;
   logic             frame_done_q;
   logic             lz_q;
   logic             boundary;
   logic             apply;
   logic             guard_end, slot_end;

   seg7_slot_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_slot_timer (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (en_i),
      .run_i       (state_q != IDLE),
      .guard_end_o (guard_end),
      .slot_end_o  (slot_end)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      boundary = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = (GUARD_CYCLES > 0) ? GUARD : SHOW;
               idx_d   = '0;
            end
         end
         GUARD: begin
            if (guard_end) state_d = SHOW;
         end
         SHOW: begin
            if (slot_end) begin
               state_d = (GUARD_CYCLES > 0) ? GUARD : SHOW;
               if (idx_q == IDX_LAST) begin
                  idx_d    = '0;
                  boundary = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!en_i) begin
         state_d  = IDLE;
         idx_d    = '0;
         boundary = 1'b0;
      end
   end

   // A load coinciding with the apply point wins over the older shadow copy.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      active_d  = active_q;
      ack_d     = 1'b0;
      apply     = (boundary && (pending_q || load_i)) || ((state_q == IDLE) && pending_q);
      if (load_i) begin
         shadow_d  = digits_in_i;
         pending_d = 1'b1;
      end
      if (apply) begin
         active_d  = load_i ? digits_in_i : shadow_q;
         pending_d = 1'b0;
         ack_d     = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         ack_q        <= 1'b0;
         frame_done_q <= 1'b0;
         lz_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         ack_q        <= ack_d;
         frame_done_q <= boundary;
         lz_q         <= lz_en_i;
      end
   end

   bcd_t act_dig [NUM_DIGITS];
   bcd_t cur_dig;
   logic upper_zero;
   logic any_err;

   always_comb begin
      upper_zero = 1'b1;
      any_err    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         act_dig[i] = active_q[4*i +: 4];
         if (act_dig[i] > BCD_MAX) any_err = 1'b1;
         if ((i >= int'(idx_q)) && (act_dig[i] != 4'd0)) upper_zero = 1'b0;
      end
      cur_dig = act_dig[idx_q];
   end

   always_comb begin
      dig_sel_o   = '0;
      bcd_out_o   = 4'd0;
      blank_out_o = 1'b1;
      if (state_q == SHOW) begin
         dig_sel_o[idx_q] = 1'b1;
         bcd_out_o        = cur_dig;
         blank_out_o      = (cur_dig > BCD_MAX) || (lz_q && (idx_q != '0) && upper_zero);
      end
   end

   assign load_ack_o   = ack_q;
   assign frame_done_o = frame_done_q;
   assign bcd_err_o    = any_err;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short 8-cycle slot and 2-cycle guard.
module tb_seg7_scan_ctrl;

   localparam int N  = 4;
   localparam int SD = 8;
   localparam int GC = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          lz_en;
   logic          load;
   logic [4*N-1:0] digits;
   logic          load_ack;
   logic [3:0]    bcd_out;
   logic          blank_out;
   logic [N-1:0]  dig_sel;
   logic          frame_done;
   logic          bcd_err;

   int checks   = 0;
   int failures = 0;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .SCAN_DIV     (SD),
      .GUARD_CYCLES (GC)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .en_i         (en),
      .lz_en_i      (lz_en),
      .load_i       (load),
      .digits_in_i  (digits),
      .load_ack_o   (load_ack),
      .bcd_out_o    (bcd_out),
      .blank_out_o  (blank_out),
      .dig_sel_o    (dig_sel),
      .frame_done_o (frame_done),
      .bcd_err_o    (bcd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // Checks one 32-cycle frame starting at the first guard cycle of digit 0.
   // Optional loads are driven right after the sample of cycle la1 / la2.
   task automatic scan_frame(input string tag, input logic [15:0] vals, input logic [3:0] bmask,
                             input bit first, input bit exp_ack, input bit exp_err,
                             input int la1, input logic [15:0] v1,
                             input int la2, input logic [15:0] v2);
      logic [3:0] e_sel;
      logic [3:0] e_bcd;
      logic       e_blank;
      int         slot;
      int         pos;
      for (int k = 0; k < N * SD; k++) begin
         slot  = k / SD;
         pos   = k % SD;
         e_sel = '0;
         e_bcd = 4'd0;
         e_blank = 1'b1;
         if (pos >= GC) begin
            e_sel[slot] = 1'b1;
            e_bcd       = vals[4*slot +: 4];
            e_blank     = bmask[slot];
         end
         chk({tag, ".sel"},   dig_sel,    e_sel);
         chk({tag, ".bcd"},   bcd_out,    e_bcd);
         chk({tag, ".blank"}, blank_out,  e_blank);
         chk({tag, ".fdone"}, frame_done, (k == 0) && !first);
         chk({tag, ".ack"},   load_ack,   (k == 0) && exp_ack);
         chk({tag, ".err"},   bcd_err,    exp_err);
         if (k == la1) begin
            load = 1'b1; digits = v1;
         end else if (k == la2) begin
            load = 1'b1; digits = v2;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; lz_en = 1'b0; load = 1'b0; digits = '0;
      repeat (3) @(negedge clk);
      chk("rst.sel",   dig_sel,    4'b0000);
      chk("rst.blank", blank_out,  1'b1);
      chk("rst.bcd",   bcd_out,    4'd0);
      chk("rst.ack",   load_ack,   1'b0);
      chk("rst.fdone", frame_done, 1'b0);
      chk("rst.err",   bcd_err,    1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Load while idle: applied the following cycle, acked one cycle after that.
      load = 1'b1; digits = 16'h1234;
      @(negedge clk);
      load = 1'b0;
      chk("idle.ack0", load_ack, 1'b0);
      @(negedge clk);
      chk("idle.ack1", load_ack, 1'b1);
      chk("idle.sel",  dig_sel,  4'b0000);
      @(negedge clk);
      chk("idle.ack2", load_ack, 1'b0);
      en = 1'b1;
      @(negedge clk);

      scan_frame("f1234a", 16'h1234, 4'b0000, 1'b1, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
      lz_en = 1'b1;
      scan_frame("f1234b", 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0, 12, 16'h9999, 20, 16'h0045);
      scan_frame("f0045",  16'h0045, 4'b1100, 1'b0, 1'b1, 1'b0, 5, 16'h0000, -1, 16'h0);
      scan_frame("f0000lz", 16'h0000, 4'b1110, 1'b0, 1'b1, 1'b0, 31, 16'h3C21, -1, 16'h0);
      scan_frame("f3C21",  16'h3C21, 4'b0100, 1'b0, 1'b1, 1'b1, 10, 16'h0000, -1, 16'h0);
      scan_frame("ferrclr", 16'h0000, 4'b1110, 1'b0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
      lz_en = 1'b0;
      scan_frame("f0000nolz", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3, 16'h0507, -1, 16'h0);

      // Drop en during digit 2 of the next frame.
      chk("h.ack",   load_ack,   1'b1);
      chk("h.fdone", frame_done, 1'b1);
      repeat (20) @(negedge clk);
      chk("h.sel2", dig_sel, 4'b0100);
      chk("h.bcd2", bcd_out, 4'd5);
      en = 1'b0;
      @(negedge clk);
      chk("off.sel",   dig_sel,   4'b0000);
      chk("off.blank", blank_out, 1'b1);
      chk("off.bcd",   bcd_out,   4'd0);
      repeat (2) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      scan_frame("restart", 16'h0507, 4'b0000, 1'b1, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);

      // Asynchronous reset between edges while digit 0 is lit.
      repeat (4) @(negedge clk);
      chk("pre.sel", dig_sel, 4'b0001);
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("arst.sel",   dig_sel,   4'b0000);
      chk("arst.blank", blank_out, 1'b1);
      chk("arst.bcd",   bcd_out,   4'd0);
      chk("arst.err",   bcd_err,   1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post.ack",   load_ack,   1'b0);
         chk("post.fdone", frame_done, 1'b0);
         chk("post.sel",   dig_sel,    4'b0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
